// File: rtl/logic_pulser.sv
// -----------------------------------------------------------------------------
// logic_pulser
//
// Board bring-up stimulus source, the counterpart of the logic probe. A
// debounced pushbutton fires one pulse, a fixed burst of pulses, or a
// continuous train while the button is held. Each pulse overdrives the node to
// the opposite of the level sensed just before the pulse starts, through the
// enable of an external tri-state pad.
//
// Ports:
//   clk          sole clock
//   reset_n      asynchronous assert, active-low reset
//   trigger      raw pushbutton (asynchronous, active-high)
//   mode         00 single, 01 burst, 10 continuous, 11 disabled / abort
//   sense        current node level (asynchronous)
//   pulse_out    level to drive onto the node; 0 whenever pulse_oe is 0
//   pulse_oe     tri-state enable for the node driver
//   busy         high in any state other than IDLE
//   pulse_count  total pulses started, wraps 255 -> 0
// -----------------------------------------------------------------------------
module logic_pulser #(
    parameter int PULSE_WIDTH = 16,
    parameter int GAP         = 1024,
    parameter int BURST_LEN   = 4,
    parameter int DEBOUNCE    = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       trigger,
    input  logic [1:0] mode,
    input  logic       sense,
    output logic       pulse_out,
    output logic       pulse_oe,
    output logic       busy,
    output logic [7:0] pulse_count
);

    // Counter widths: each counter only ever holds 0 .. parameter-1.
    localparam int DB_W = (DEBOUNCE    > 1) ? $clog2(DEBOUNCE)    : 1;
    localparam int PW_W = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;
    localparam int GP_W = (GAP         > 1) ? $clog2(GAP)         : 1;
    localparam int BL_W = (BURST_LEN   > 1) ? $clog2(BURST_LEN)   : 1;
    localparam int TM_W = (PW_W > GP_W) ? PW_W : GP_W;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [TM_W-1:0] PW_LAST = TM_W'(PULSE_WIDTH - 1);
    localparam logic [TM_W-1:0] GP_LAST = TM_W'(GAP - 1);
    localparam logic [TM_W-1:0] TM_ONE  = TM_W'(1);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BURST_LEN - 1);
    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_BURST  = 2'b01;
    localparam logic [1:0] MODE_CONT   = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic            trig_p0;
    logic            trig_p1;
    logic            sense_p0;
    logic            sense_p1;
    logic            trig_db;
    logic            trig_db_d;
    logic [DB_W-1:0] db_cnt;
    logic            fire;

    logic [1:0]      state;
    logic [1:0]      mode_q;
    logic            pol;
    logic [TM_W-1:0] tmr;
    logic [BL_W-1:0] burst_cnt;

    // ---- stage boundary: 2-flop synchronizers for the asynchronous inputs ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_p0  <= 1'b0;
            trig_p1  <= 1'b0;
            sense_p0 <= 1'b0;
            sense_p1 <= 1'b0;
        end else begin
            trig_p0  <= trigger;
            trig_p1  <= trig_p0;
            sense_p0 <= sense;
            sense_p1 <= sense_p0;
        end
    end

    // ---- stage boundary: debounce ----
    // The count only advances while the synchronized trigger disagrees with the
    // debounced value; any agreement (a glitch back) clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trig_db   <= 1'b0;
            trig_db_d <= 1'b0;
            db_cnt    <= '0;
        end else begin
            trig_db_d <= trig_db;
            if (trig_p1 != trig_db) begin
                if (db_cnt == DB_LAST) begin
                    trig_db <= trig_p1;
                    db_cnt  <= '0;
                end else begin
                    db_cnt <= db_cnt + DB_ONE;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign fire = trig_db & ~trig_db_d;

    // ---- stage boundary: pulse sequencer ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            mode_q      <= MODE_SINGLE;
            pol         <= 1'b0;
            tmr         <= '0;
            burst_cnt   <= '0;
            pulse_count <= 8'd0;
        end else if ((state != S_IDLE) && (mode == MODE_OFF)) begin
            // Live abort: the pad is released on the next edge, count kept.
            state <= S_IDLE;
            tmr   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fire && (mode != MODE_OFF)) begin
                        mode_q      <= mode;
                        pol         <= ~sense_p1;
                        burst_cnt   <= BL_LAST;
                        tmr         <= '0;
                        pulse_count <= pulse_count + 8'd1;
                        state       <= S_PULSE;
                    end
                end
                S_PULSE: begin
                    if (tmr == PW_LAST) begin
                        tmr   <= '0;
                        state <= S_GAP;
                    end else begin
                        tmr <= tmr + TM_ONE;
                    end
                end
                S_GAP: begin
                    if (tmr == GP_LAST) begin
                        tmr   <= '0;
                        state <= S_IDLE;
                        case (mode_q)
                            MODE_BURST: begin
                                if (burst_cnt != '0) begin
                                    burst_cnt   <= burst_cnt - BL_ONE;
                                    pol         <= ~sense_p1;
                                    pulse_count <= pulse_count + 8'd1;
                                    state       <= S_PULSE;
                                end
                            end
                            MODE_CONT: begin
                                if (trig_db) begin
                                    pol         <= ~sense_p1;
                                    pulse_count <= pulse_count + 8'd1;
                                    state       <= S_PULSE;
                                end
                            end
                            default: begin
                                state <= S_IDLE;
                            end
                        endcase
                    end else begin
                        tmr <= tmr + TM_ONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tmr   <= '0;
                end
            endcase
        end
    end

    // Outputs decode straight from the state register so an asynchronous
    // reset releases the pad immediately.
    assign pulse_oe  = (state == S_PULSE);
    assign pulse_out = pulse_oe & pol;
    assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_logic_pulser.sv
// -----------------------------------------------------------------------------
// tb_logic_pulser
//
// Scoreboard bench for logic_pulser with PULSE_WIDTH=4, GAP=8, BURST_LEN=3,
// DEBOUNCE=4. Stimulus pushes the pulses it expects (level, running count,
// width, spacing from the previous pulse); a negedge monitor pops one entry
// per observed pulse_oe rise and checks it. Directed checks cover latency,
// busy length, glitch rejection, abort, wrap and asynchronous reset.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_logic_pulser;

    localparam int PW = 4;
    localparam int GP = 8;
    localparam int BL = 3;
    localparam int DB = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       trigger = 1'b0;
    logic [1:0] mode    = 2'b00;
    logic       sense   = 1'b0;
    logic       pulse_out;
    logic       pulse_oe;
    logic       busy;
    logic [7:0] pulse_count;

    logic_pulser #(
        .PULSE_WIDTH(PW),
        .GAP        (GP),
        .BURST_LEN  (BL),
        .DEBOUNCE   (DB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trigger    (trigger),
        .mode       (mode),
        .sense      (sense),
        .pulse_out  (pulse_out),
        .pulse_oe   (pulse_oe),
        .busy       (busy),
        .pulse_count(pulse_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic pol;
        int   cnt;
        int   width;   // 0: not checked (pulse cut short on purpose)
        int   period;  // 0: not checked (first pulse of a sequence)
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, want);
        end
    endtask

    task automatic push_exp(input logic pol, input int cnt, input int width, input int period);
        exp_t e;
        e.pol    = pol;
        e.cnt    = cnt;
        e.width  = width;
        e.period = period;
        sb.push_back(e);
    endtask

    // ---------------------------------------------------------------- monitor
    int   cyc       = 0;
    int   last_rise = -1;
    int   width_seen = 0;
    logic prev_oe   = 1'b0;
    logic have_cur  = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            prev_oe    = 1'b0;
            have_cur   = 1'b0;
            width_seen = 0;
            last_rise  = -1;
        end else begin
            if (pulse_oe && !prev_oe) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: pulse started with pulse_count %0d, none expected", pulse_count);
                    have_cur = 1'b0;
                end else begin
                    cur      = sb.pop_front();
                    have_cur = 1'b1;
                    chk("pulse_count_at_start", int'(pulse_count), cur.cnt);
                    if (cur.period != 0 && last_rise >= 0)
                        chk("pulse_period", cyc - last_rise, cur.period);
                end
                last_rise  = cyc;
                width_seen = 0;
            end
            if (pulse_oe) begin
                width_seen++;
                if (have_cur) chk("pulse_out_level", int'(pulse_out), int'(cur.pol));
            end else begin
                chk("pulse_out_zero_when_off", int'(pulse_out), 0);
            end
            if (!pulse_oe && prev_oe && have_cur) begin
                if (cur.width != 0) chk("pulse_width", width_seen, cur.width);
                have_cur = 1'b0;
            end
            prev_oe = pulse_oe;
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_oe(input string name, output int n);
        n = 0;
        while (!pulse_oe && n < 50) begin
            tick(1);
            n++;
        end
        if (!pulse_oe) begin
            checks++;
            errors++;
            $display("FAIL %s: pulse_oe still 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    task automatic wait_count(input string name, input int target);
        int n;
        n = 0;
        while (int'(pulse_count) != target && n < 200) begin
            tick(1);
            n++;
        end
        if (int'(pulse_count) != target) begin
            checks++;
            errors++;
            $display("FAIL %s: pulse_count %0d after %0d cycles, expected %0d", name, pulse_count, n, target);
        end
    endtask

    // Number of consecutive samples (starting now) with busy high.
    task automatic busy_run(input string name, output int b);
        b = 0;
        while (busy && b < 200) begin
            b++;
            tick(1);
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, b);
        end
    endtask

    task automatic do_reset();
        chk("scoreboard_drained", sb.size(), 0);
        sb.delete();
        trigger = 1'b0;
        reset_n = 1'b0;
        tick(2);
        chk("reset_pulse_oe", int'(pulse_oe), 0);
        chk("reset_pulse_out", int'(pulse_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_pulse_count", int'(pulse_count), 0);
        reset_n = 1'b1;
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b;

        tick(1);
        do_reset();

        // 1: single mode, sense low -> one high pulse
        mode  = 2'b00;
        sense = 1'b0;
        tick(3);
        push_exp(1'b1, 1, PW, 0);
        trigger = 1'b1;
        wait_oe("t1_rise", n);
        chk("t1_latency", n, 7);
        busy_run("t1_busy", b);
        chk("t1_busy_cycles", b, PW + GP);
        tick(2);
        trigger = 1'b0;
        tick(20);
        chk("t1_pulse_count", int'(pulse_count), 1);
        chk("t1_idle_oe", int'(pulse_oe), 0);

        // 2: short glitches never fire
        do_reset();
        trigger = 1'b1; tick(2);
        trigger = 1'b0; tick(4);
        trigger = 1'b1; tick(3);
        trigger = 1'b0; tick(4);
        trigger = 1'b1; tick(2);
        trigger = 1'b0; tick(12);
        chk("t2_pulse_count", int'(pulse_count), 0);
        chk("t2_pulse_oe", int'(pulse_oe), 0);
        chk("t2_busy", int'(busy), 0);

        // 3: burst mode, sense high -> three low pulses, second press ignored
        do_reset();
        mode  = 2'b01;
        sense = 1'b1;
        tick(3);
        push_exp(1'b0, 1, PW, 0);
        push_exp(1'b0, 2, PW, PW + GP);
        push_exp(1'b0, 3, PW, PW + GP);
        trigger = 1'b1; tick(8);
        trigger = 1'b0; tick(12);
        trigger = 1'b1; tick(8);
        trigger = 1'b0;
        busy_run("t3_busy", b);
        tick(40);
        chk("t3_pulse_count", int'(pulse_count), 3);
        chk("t3_busy", int'(busy), 0);
        chk("t3_all_pulses_seen", sb.size(), 0);

        // 4: continuous mode, sense flips during pulse 1, release during pulse 5
        do_reset();
        mode  = 2'b10;
        sense = 1'b0;
        tick(3);
        push_exp(1'b1, 1, PW, 0);
        push_exp(1'b0, 2, PW, PW + GP);
        push_exp(1'b0, 3, PW, PW + GP);
        push_exp(1'b0, 4, PW, PW + GP);
        push_exp(1'b0, 5, PW, PW + GP);
        trigger = 1'b1;
        wait_oe("t4_rise", n);
        sense = 1'b1;
        wait_count("t4_reach5", 5);
        trigger = 1'b0;
        busy_run("t4_busy", b);
        chk("t4_last_pulse_busy_cycles", b, PW + GP);
        tick(30);
        chk("t4_pulse_count", int'(pulse_count), 5);
        chk("t4_all_pulses_seen", sb.size(), 0);

        // 5: abort during the second burst pulse
        do_reset();
        mode  = 2'b01;
        sense = 1'b0;
        tick(3);
        push_exp(1'b1, 1, PW, 0);
        push_exp(1'b1, 2, 0, PW + GP);
        trigger = 1'b1; tick(8);
        trigger = 1'b0;
        wait_count("t5_reach2", 2);
        tick(1);
        chk("t5_mid_pulse_oe", int'(pulse_oe), 1);
        mode = 2'b11;
        tick(1);
        chk("t5_abort_oe", int'(pulse_oe), 0);
        chk("t5_abort_busy", int'(busy), 0);
        chk("t5_abort_count", int'(pulse_count), 2);
        mode = 2'b01;
        tick(40);
        chk("t5_no_more_pulses", int'(pulse_count), 2);

        // 6: 256 single pulses wrap the counter, then async reset mid-pulse
        do_reset();
        mode  = 2'b00;
        sense = 1'b0;
        tick(3);
        for (int i = 1; i <= 256; i++) begin
            push_exp(1'b1, i % 256, PW, 0);
            trigger = 1'b1;
            tick(6);
            trigger = 1'b0;
            wait_oe("t6_rise", n);
            busy_run("t6_busy", b);
            tick(2);
            if (i == 255) chk("t6_count_255", int'(pulse_count), 255);
        end
        chk("t6_wrap_count", int'(pulse_count), 0);
        push_exp(1'b1, 1, 0, 0);
        trigger = 1'b1;
        wait_oe("t6_rise_257", n);
        tick(1);
        trigger = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_oe", int'(pulse_oe), 0);
        chk("t6_async_out", int'(pulse_out), 0);
        chk("t6_async_busy", int'(busy), 0);
        chk("t6_async_count", int'(pulse_count), 0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        chk("t6_post_oe", int'(pulse_oe), 0);
        chk("t6_post_busy", int'(busy), 0);
        chk("t6_post_count", int'(pulse_count), 0);
        chk("t6_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
